// File: rtl/mul_controller.sv
// Control FSM for the repeated-addition multiplier: operand handshake, load/clear/
// accumulate/decrement strobes, DONE hold until ack, and an LdP pulse counter.
module mul_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eqz,
  input  logic             ack,
  output logic             LdA,
  output logic             LdB,
  output logic             clrP,
  output logic             LdP,
  output logic             decB,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    LdA     = 1'b0;
    LdB     = 1'b0;
    clrP    = 1'b0;
    LdP     = 1'b0;
    decB    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (in_valid) begin
          LdA     = 1'b1;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (in_valid) begin
          LdB     = 1'b1;
          clrP    = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (eqz) begin
          state_d = S_DONE;
        end else begin
          LdP  = 1'b1;
          decB = 1'b1;
        end
      end
      S_DONE: begin
        if (ack) state_d = start ? S_LOAD_A : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides everything, including strobes already decoded this cycle
    if (abort) begin
      state_d = S_IDLE;
      LdA     = 1'b0;
      LdB     = 1'b0;
      clrP    = 1'b0;
      LdP     = 1'b0;
      decB    = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clrP)     cnt_d = '0;
    else if (LdP) cnt_d = cnt_q + 1'b1;
  end

  assign in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign busy     = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_ADD);
  assign done     = (state_q == S_DONE);
  assign iter_cnt = cnt_q;

endmodule

// File: doc/mul_controller.md
# mul_controller

Control FSM for the repeated-addition multiplier. It takes two 16-bit operands over a valid/ready handshake on the shared `data_in` bus and sequences the datapath load, clear, decrement and accumulate strobes until the datapath reports B = 0. It then holds `done` until the result is acknowledged. It connects directly to the datapath's `LdA`, `LdB`, `LdP`, `clrP`, `decB` inputs and `eqz` output.

## Interface
- `CNT_W`, default 16: width of the `iter_cnt` accumulate-count output.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new multiplication; sampled only in IDLE or DONE.
- `abort`  in  1  synchronous abort; returns the block to IDLE from any state.
- `in_valid`  in  1  upstream has an operand on `data_in`.
- `in_ready`  out  1  block will accept an operand this cycle.
- `eqz`  in  1  datapath flag: B counter equals zero.
- `ack`  in  1  consumer has read P; releases DONE.
- `LdA`  out  1  load A register from bus.
- `LdB`  out  1  load B down-counter from bus.
- `clrP`  out  1  clear P register.
- `LdP`  out  1  load P with A+P.
- `decB`  out  1  decrement B counter.
- `busy`  out  1  high in LOAD_A, LOAD_B, ADD.
- `done`  out  1  high in DONE; P holds A*B.
- `iter_cnt`  out  CNT_W  number of `LdP` pulses issued for the current or last operation.

## Operation
- The state is one of IDLE, LOAD_A, LOAD_B, ADD, DONE. Reset forces IDLE.
- `abort` has the highest priority. When `abort` is high, the next state is IDLE and all strobes are forced to 0 that cycle.
- IDLE:
  - `start` → LOAD_A.
  - Otherwise stay in IDLE.
- LOAD_A:
  - `in_ready` = 1.
  - `in_valid` → `LdA` = 1, go to LOAD_B.
  - Otherwise wait.
- LOAD_B:
  - `in_ready` = 1.
  - `in_valid` → `LdB` = 1, `clrP` = 1, `iter_cnt` cleared to 0, go to ADD.
  - Otherwise wait.
- ADD:
  - `eqz` = 0 → `LdP` = 1, `decB` = 1, `iter_cnt` += 1, stay in ADD.
  - `eqz` = 1 → no strobes, go to DONE.
- DONE:
  - `done` = 1.
  - `ack` and `start` both high → LOAD_A (back-to-back operation).
  - `ack` alone → IDLE.
  - Neither → stay in DONE.
- `start` outside IDLE and DONE is ignored.
- `in_valid` outside LOAD_A and LOAD_B is ignored; `in_ready` = 0 there.
- Output types:
  - `in_ready`, `busy` and `done` are Moore outputs, decoded from the state only.
  - `LdA`, `LdB`, `clrP`, `LdP` and `decB` are Mealy outputs: the state gated by `in_valid` or `eqz`, and by `!abort`.
  - At most one of {`LdA`, `LdB`, `LdP`} is high per cycle. `clrP` coincides only with `LdB`.
- `iter_cnt`:
  - Wraps modulo 2^CNT_W. No saturation.
  - Holds its value in DONE and IDLE, and across `abort`.
- B = 0 operand: ADD sees `eqz` = 1 on its first cycle → DONE with P = 0 and `iter_cnt` = 0.
- A = 0 operand: a normal B-iteration run that accumulates zeros.

## Timing
- Reset values: state IDLE; all outputs 0; `iter_cnt` = 0.
- `rst_n` low mid-operation immediately returns the block to IDLE with all strobes low. Datapath contents are don't-care afterwards.
- `start` is sampled at edge k; LOAD_A is active in cycle k+1.
- Operand transfer occurs on a cycle with `in_valid` & `in_ready`. The datapath register captures at the end of that cycle.
- `eqz` is valid in the first ADD cycle because B was loaded at the LOAD_B edge.
- ADD lasts B+1 cycles.
- Minimum latency from the `start` edge to the first `done` cycle is B+4 cycles: LOAD_A 1, LOAD_B 1, ADD B+1, then DONE.
- Operand stalls add one cycle each.
- `done` stays high until the edge at which `ack` is sampled.
- `abort` or `rst_n` take effect at the following edge (`rst_n` asynchronously). Strobes are suppressed combinationally in the abort cycle.

## Test plan
- Reset, then A = 5, B = 3, with `in_valid` held high → `LdP` high for 3 cycles and `done` in cycle 7 after the start edge. Check P = 15 and `iter_cnt` = 3. `ack` → IDLE.
- B = 0, A = 0x1234 → ADD lasts 1 cycle and `done` arrives in cycle 4. Check P = 0 and `iter_cnt` = 0 with no `LdP` pulse.
- Stall `in_valid` low 2 cycles in LOAD_A and 3 cycles in LOAD_B → `in_ready` high throughout, `LdA`/`LdB` only on the valid cycles, `done` 5 cycles later than with no stall.
- `abort` on the second ADD cycle of A = 7, B = 10 → no strobes that cycle, IDLE next, `busy` = 0, `iter_cnt` holds 1. A new `start` runs correctly: A = 2, B = 2 gives P = 4.
- In DONE, assert `ack` and `start` together → next state LOAD_A and `in_ready` = 1. `start` pulses while busy are ignored.
- Assert `rst_n` low mid-ADD → all outputs 0 immediately, IDLE after release. Random A,B < 64 over 200 runs → P = A*B and `iter_cnt` = B.
